gate_sweep_checker: RTL

GATE_SWEEP_CHECKER -- requirements
Module: gate_sweep_checker

---
 rtl/gate_sweep_checker.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/gate_sweep_checker.sv
// Sweeps all four input pairs through a 2-input gate and checks its output.
// Optional first-failure logging: define GATE_SWEEP_FAIL_LOG_EN.
module gate_sweep_checker #(
  parameter int HOLD_CYCLES = 100
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [2:0] op,
  input  logic       dut_out,
  output logic       in1,
  output logic       in2,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic       mismatch,
  output logic [2:0] err_count,
  output logic [1:0] fail_vec
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [9:0] LAST = 10'(HOLD_CYCLES - 1);

  state_t      r_state, w_state_nxt;
  logic [2:0]  r_op;
  logic [1:0]  r_vec;
  logic [9:0]  r_cnt;
  logic [2:0]  r_err;
  logic        r_busy, r_done, r_pass, r_mis;

  logic        w_accept, w_last, w_final;
  logic        w_valid, w_exp, w_fail;
  logic [2:0]  w_err_nxt;

  assign w_accept = (r_state != DRIVE) && start;
  assign w_last   = (r_cnt == LAST);
  assign w_final  = (r_vec == 2'b11);

  always_comb begin
    w_valid = 1'b1;
    w_exp   = 1'b0;
    unique case (r_op)
      3'd0:    w_exp = r_vec[1] & r_vec[0];
      3'd1:    w_exp = r_vec[1] | r_vec[0];
      3'd2:    w_exp = ~(r_vec[1] & r_vec[0]);
      3'd3:    w_exp = ~(r_vec[1] | r_vec[0]);
      3'd4:    w_exp = r_vec[1] ^ r_vec[0];
      3'd5:    w_exp = ~(r_vec[1] ^ r_vec[0]);
      default: w_valid = 1'b0;
    endcase
  end

  // Reserved ops fail every vector regardless of the gate output.
  assign w_fail    = !w_valid || (dut_out != w_exp);
  assign w_err_nxt = (w_fail && r_err != 3'd4) ? r_err + 3'd1 : r_err;

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (start) w_state_nxt = DRIVE;
      DRIVE:   if (w_last && w_final) w_state_nxt = DONE;
      DONE:    if (start) w_state_nxt = DRIVE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op   <= 3'd0;
      r_vec  <= 2'b00;
      r_cnt  <= 10'd0;
      r_err  <= 3'd0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_pass <= 1'b0;
      r_mis  <= 1'b0;
    end else begin
      r_mis <= 1'b0;
      if (w_accept) begin
        r_op   <= op;
        r_vec  <= 2'b00;
        r_cnt  <= 10'd0;
        r_err  <= 3'd0;
        r_busy <= 1'b1;
        r_done <= 1'b0;
        r_pass <= 1'b0;
      end else if (r_state == DRIVE) begin
        if (w_last) begin
          r_cnt <= 10'd0;
          r_mis <= w_fail;
          r_err <= w_err_nxt;
          if (w_final) begin
            r_vec  <= 2'b00;
            r_busy <= 1'b0;
            r_done <= 1'b1;
            r_pass <= (w_err_nxt == 3'd0);
          end else begin
            r_vec <= r_vec + 2'd1;
          end
        end else begin
          r_cnt <= r_cnt + 10'd1;
        end
      end
    end
  end

`ifdef GATE_SWEEP_FAIL_LOG_EN
  logic [1:0] r_fv;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_fv <= 2'b00;
    else if (w_accept)
      r_fv <= 2'b00;
    else if (r_state == DRIVE && w_last && w_fail && r_err == 3'd0)
      r_fv <= r_vec;
  end

  assign fail_vec = r_fv;
`else
  assign fail_vec = 2'b00;
`endif

  assign in1       = r_vec[1];
  assign in2       = r_vec[0];
  assign busy      = r_busy;
  assign done      = r_done;
  assign pass      = r_pass;
  assign mismatch  = r_mis;
  assign err_count = r_err;

endmodule
